// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32 core's load/store port: one request at a
// time, answered after LATENCY wait states with a single-cycle MemReady strobe.
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReq,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] DataAdr,
  input  logic [31:0]       WriteData,
  input  logic [3:0]        ByteEn,
  output logic [31:0]       ReadData,
  output logic              MemReady,
  output logic              AddrErr,
  output logic [1:0]        dbg_state_o
);

  // Handshake: the initiator raises MemReq with MemWrite/DataAdr/WriteData/
  // ByteEn and holds them until it sees MemReady. A request is taken only in
  // IDLE, so at most one access is ever in flight. MemReady pulses for exactly
  // one cycle; ReadData and AddrErr are meaningful only in that cycle.

  localparam int CNT_W   = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam int WIDX_W  = ADDR_W - 2;
  localparam int IDX_W   = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be within 0..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         mem_q [DEPTH];

  logic                accept;
  logic                enter_resp;
  logic                cur_wr;
  logic [WIDX_W-1:0]   cur_widx;
  logic                cur_in_range;
  logic                lat_in_range;
  logic                unused_adr_lsbs;

  // Byte-offset bits carry no meaning: every access is a whole aligned word.
  assign unused_adr_lsbs = ^DataAdr[1:0];

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      widx_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
    end
  end

  // ------------------------------------------------------------ next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (MemReq) state_d = (LATENCY == 0) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q <= CNT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------ request datapath
  always_comb begin
    accept  = (state_q == ST_IDLE) && MemReq;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    widx_d  = widx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    if (accept) begin
      cnt_d   = CNT_W'(LATENCY);
      wr_d    = MemWrite;
      widx_d  = DataAdr[ADDR_W-1:2];
      wdata_d = WriteData;
      be_d    = ByteEn;
    end else if (state_q == ST_WAIT && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // With LATENCY==0 RESP is entered straight from IDLE, so the read must use
  // the live request rather than the latched copy.
  always_comb begin
    cur_wr       = accept ? MemWrite : wr_q;
    cur_widx     = accept ? DataAdr[ADDR_W-1:2] : widx_q;
    cur_in_range = (cur_widx < WIDX_W'(DEPTH));
    lat_in_range = (widx_q < WIDX_W'(DEPTH));
    enter_resp   = (state_d == ST_RESP) && (state_q != ST_RESP);
    rdata_d      = '0;
    if (enter_resp && !cur_wr && cur_in_range) begin
      rdata_d = mem_q[cur_widx[IDX_W-1:0]];
    end
  end

  // Stores commit on the edge that ends RESP; a reset in that cycle drops them.
  always_ff @(posedge clk) begin
    if (reset && state_q == ST_RESP && wr_q && lat_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem_q[widx_q[IDX_W-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  // -------------------------------------------------------------- outputs
  always_comb begin
    MemReady    = (state_q == ST_RESP);
    AddrErr     = (state_q == ST_RESP) && !lat_in_range;
    ReadData    = (state_q == ST_RESP) ? rdata_q : 32'h0;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=2 and one at
// LATENCY=0, every expected value written out by hand.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        MemReq, MemWrite;
  logic [31:0] DataAdr, WriteData, ReadData;
  logic [3:0]  ByteEn;
  logic        MemReady, AddrErr;
  logic [1:0]  dbg_state;

  logic        r0_req, r0_wr;
  logic [31:0] r0_adr, r0_wdata, r0_rdata;
  logic [3:0]  r0_be;
  logic        r0_ready, r0_err;
  logic [1:0]  r0_state;

  int n_vec;
  int n_err;

  // ------------------------------------------------------------ clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .LATENCY(2), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .MemReq(MemReq), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .ByteEn(ByteEn),
    .ReadData(ReadData), .MemReady(MemReady), .AddrErr(AddrErr),
    .dbg_state_o(dbg_state)
  );

  dmem_responder #(.DEPTH(64), .LATENCY(0), .ADDR_W(32)) dut0 (
    .clk(clk), .reset(reset),
    .MemReq(r0_req), .MemWrite(r0_wr), .DataAdr(r0_adr),
    .WriteData(r0_wdata), .ByteEn(r0_be),
    .ReadData(r0_rdata), .MemReady(r0_ready), .AddrErr(r0_err),
    .dbg_state_o(r0_state)
  );

  // ------------------------------------------------------------ checking
  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------ driver
  // Presents a request, waits for MemReady (bounded), returns the response,
  // then confirms the strobe lasted one cycle. lat==0 means it never came.
  task automatic access(input logic wr, input logic [31:0] adr,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rd, output logic err,
                        output int lat);
    MemReq = 1'b1; MemWrite = wr; DataAdr = adr; WriteData = wd; ByteEn = be;
    lat = 0; rd = '0; err = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (MemReady) begin
        lat = i; rd = ReadData; err = AddrErr;
        break;
      end
    end
    MemReq = 1'b0;
    tick();
    check_val("strobe_one_cycle", {31'd0, MemReady}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat;
  int          seen;

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b0;
    MemReq = 0; MemWrite = 0; DataAdr = 0; WriteData = 0; ByteEn = 0;
    r0_req = 0; r0_wr = 0; r0_adr = 0; r0_wdata = 0; r0_be = 0;
    repeat (3) tick();

    check_val("rst_ready",  {31'd0, MemReady}, 32'd0);
    check_val("rst_err",    {31'd0, AddrErr},  32'd0);
    check_val("rst_rdata",  ReadData, 32'd0);
    check_val("rst_state",  {30'd0, dbg_state}, 32'd0);

    // Outputs stay quiet after release until something is accepted.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("idle_quiet", {MemReady, AddrErr, ReadData[29:0]}, 32'd0);
    end

    // Store then load, LATENCY=2 -> strobe three edges after presentation.
    access(1'b1, 32'd100, 32'd25, 4'b1111, rd, err, lat);
    check_val("st100_lat", lat, 32'd3);
    check_val("st100_err", {31'd0, err}, 32'd0);
    access(1'b0, 32'd100, 32'd0, 4'b0000, rd, err, lat);
    check_val("ld100_lat",  lat, 32'd3);
    check_val("ld100_data", rd, 32'd25);
    check_val("ld100_err",  {31'd0, err}, 32'd0);

    // Byte-lane merge.
    access(1'b1, 32'd8, 32'h1122_3344, 4'b1111, rd, err, lat);
    access(1'b1, 32'd8, 32'hAABB_CCDD, 4'b0010, rd, err, lat);
    access(1'b0, 32'd8, 32'd0, 4'b0000, rd, err, lat);
    check_val("lane1_merge", rd, 32'h1122_CC44);

    // Empty byte-enable still handshakes but leaves the word alone.
    access(1'b1, 32'd8, 32'hFFFF_FFFF, 4'b0000, rd, err, lat);
    check_val("be0_lat", lat, 32'd3);
    access(1'b0, 32'd8, 32'd0, 4'b0000, rd, err, lat);
    check_val("be0_noop", rd, 32'h1122_CC44);

    // Byte offset bits are ignored.
    access(1'b0, 32'd11, 32'd0, 4'b0000, rd, err, lat);
    check_val("unaligned_ld", rd, 32'h1122_CC44);

    // Range boundary: word 63 valid, word 64 (addr 256) is not and must not
    // wrap onto word 0.
    access(1'b1, 32'd0, 32'hCAFE_F00D, 4'b1111, rd, err, lat);
    access(1'b1, 32'd252, 32'h0000_0063, 4'b1111, rd, err, lat);
    check_val("st252_err", {31'd0, err}, 32'd0);
    access(1'b0, 32'd252, 32'd0, 4'b0000, rd, err, lat);
    check_val("ld252_data", rd, 32'h0000_0063);
    access(1'b1, 32'd256, 32'hDEAD_BEEF, 4'b1111, rd, err, lat);
    check_val("st256_lat", lat, 32'd3);
    check_val("st256_err", {31'd0, err}, 32'd1);
    access(1'b0, 32'd0, 32'd0, 4'b0000, rd, err, lat);
    check_val("ld0_intact", rd, 32'hCAFE_F00D);
    check_val("ld0_err",    {31'd0, err}, 32'd0);
    access(1'b0, 32'd256, 32'd0, 4'b0000, rd, err, lat);
    check_val("ld256_data", rd, 32'd0);
    check_val("ld256_err",  {31'd0, err}, 32'd1);

    // Reset during WAIT drops the latched store.
    access(1'b1, 32'd96, 32'h0000_0077, 4'b1111, rd, err, lat);
    MemReq = 1'b1; MemWrite = 1'b1; DataAdr = 32'd96;
    WriteData = 32'h5; ByteEn = 4'b1111;
    tick();
    check_val("abort_in_wait", {30'd0, dbg_state}, 32'd1);
    reset = 1'b0; MemReq = 1'b0;
    tick();
    check_val("abort_state", {30'd0, dbg_state}, 32'd0);
    check_val("abort_ready", {31'd0, MemReady}, 32'd0);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (MemReady) seen++;
    end
    check_val("abort_no_strobe", seen, 32'd0);
    access(1'b0, 32'd96, 32'd0, 4'b0000, rd, err, lat);
    check_val("abort_mem_kept", rd, 32'h0000_0077);

    // Inputs wiggling during WAIT do not disturb the latched load.
    MemReq = 1'b1; MemWrite = 1'b0; DataAdr = 32'd100; ByteEn = 4'b1111;
    WriteData = 32'h1234_5678;
    tick();
    MemReq = 1'b0; MemWrite = 1'b1; DataAdr = 32'd8;
    tick();
    MemReq = 1'b1;
    tick();
    MemReq = 1'b0;
    check_val("wiggle_ready", {31'd0, MemReady}, 32'd1);
    check_val("wiggle_data",  ReadData, 32'd25);
    tick();
    access(1'b0, 32'd8, 32'd0, 4'b0000, rd, err, lat);
    check_val("wiggle_no_store", rd, 32'h1122_CC44);

    // LATENCY=0 instance: seed two words, then back-to-back loads with
    // MemReq held high across the RESP cycle.
    r0_req = 1'b1; r0_wr = 1'b1; r0_adr = 32'd4; r0_wdata = 32'h0000_ABCD;
    r0_be = 4'b1111;
    tick();
    check_val("l0_st_ready", {31'd0, r0_ready}, 32'd1);
    r0_req = 1'b0;
    tick();
    r0_req = 1'b1; r0_adr = 32'd12; r0_wdata = 32'h0000_1234;
    tick();
    r0_req = 1'b0;
    tick();
    r0_req = 1'b1; r0_wr = 1'b0; r0_adr = 32'd4;
    tick();
    check_val("l0_b2b_n1_ready", {31'd0, r0_ready}, 32'd1);
    check_val("l0_b2b_n1_data",  r0_rdata, 32'h0000_ABCD);
    r0_adr = 32'd12;
    tick();
    check_val("l0_b2b_n2_ready", {31'd0, r0_ready}, 32'd0);
    check_val("l0_b2b_n2_data",  r0_rdata, 32'd0);
    tick();
    check_val("l0_b2b_n3_ready", {31'd0, r0_ready}, 32'd1);
    check_val("l0_b2b_n3_data",  r0_rdata, 32'h0000_1234);
    r0_req = 1'b0;
    tick();
    check_val("l0_done_ready", {31'd0, r0_ready}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
